// File: rtl/frame_seg_pkg.sv
// frame_seg_pkg: shared types and constants for the frame segmenter.
// Header word layout: {frame_cnt[7:0], seg_idx[7:0], seg_words[15:0]}.
package frame_seg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HDR,
        S_DATA,
        S_GAP
    } seg_state_t;

    localparam int FRAME_CNT_W   = 8;
    localparam int SEG_IDX_W     = 8;
    localparam int SEG_WORDS_W   = 16;
    localparam int SEG_WORDS_LSB = 0;
    localparam int SEG_IDX_LSB   = SEG_WORDS_LSB + SEG_WORDS_W;
    localparam int FRAME_CNT_LSB = SEG_IDX_LSB + SEG_IDX_W;
    localparam int BYTE_SHIFT    = 2;

    function automatic logic [31:0] pack_hdr(
        input logic [FRAME_CNT_W-1:0] fc,
        input logic [SEG_IDX_W-1:0]   si,
        input logic [SEG_WORDS_W-1:0] sw
    );
        logic [31:0] w;
        w = '0;
        w[FRAME_CNT_LSB +: FRAME_CNT_W] = fc;
        w[SEG_IDX_LSB   +: SEG_IDX_W]   = si;
        w[SEG_WORDS_LSB +: SEG_WORDS_W] = sw;
        return w;
    endfunction

endpackage

// File: rtl/frame_seg_gap_timer.sv
// frame_seg_gap_timer: loadable down-counter that times the inter-packet gap.
// done is high whenever the count has reached zero.
module frame_seg_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/frame_segmenter.sv
// frame_segmenter: splits acquired frames into UDP-sized packets.
// Optional per-packet header word is compiled in with FRAME_SEG_HDR_EN.
module frame_segmenter
    import frame_seg_pkg::*;
#(
    parameter int MAX_PKT_WORDS = 360,
    parameter int GAP_CYCLES    = 16
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        i_frame_ready,
    input  logic [15:0] i_frame_size,
    input  logic [31:0] i_in_data,
    input  logic        i_in_vld,
    output logic        o_in_rdy,
    output logic [31:0] o_out_data,
    output logic        o_out_vld,
    input  logic        i_out_rdy,
    output logic        o_pkt_sync,
    output logic [15:0] o_pkt_len,
    output logic        o_busy,
    output logic [15:0] o_frame_drop
);

    localparam logic [15:0] MAX_W    = 16'(MAX_PKT_WORDS);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);
`ifdef FRAME_SEG_HDR_EN
    localparam logic [15:0] HDR_WORDS = 16'd1;
`else
    localparam logic [15:0] HDR_WORDS = 16'd0;
`endif

    seg_state_t  state;
    seg_state_t  next_state;
    logic [15:0] remain;
    logic [15:0] word_cnt;
    logic [15:0] seg_next;
    logic [15:0] pkt_len;
    logic [15:0] drop_cnt;
    logic        pkt_sync;
    logic        start_ok;
    logic        seg_load;
    logic        accept;
    logic        last_word;
    logic        gap_done;
    logic        gap_end;

    assign start_ok  = (state == S_IDLE) && i_frame_ready
                     && (i_frame_size != 16'd0);
    // START spans two cycles: compute, then pulse sync
    assign seg_load  = (state == S_START) && !pkt_sync;
    assign seg_next  = (remain < MAX_W) ? remain : MAX_W;
    assign accept    = (state == S_DATA) && i_in_vld && i_out_rdy;
    assign last_word = accept && (word_cnt == 16'd1);
    assign gap_end   = (state == S_GAP) && gap_done;

    frame_seg_gap_timer #(
        .W(8)
    ) u_gap (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .load     (last_word),
        .load_val (GAP_LOAD),
        .done     (gap_done)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (start_ok) next_state = S_START;
            S_START: begin
                if (pkt_sync) begin
`ifdef FRAME_SEG_HDR_EN
                    next_state = S_HDR;
`else
                    next_state = S_DATA;
`endif
                end
            end
            S_HDR:   if (i_out_rdy) next_state = S_DATA;
            S_DATA:  if (last_word) next_state = S_GAP;
            S_GAP: begin
                if (gap_done) begin
                    next_state = (remain != 16'd0) ? S_START : S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            remain   <= '0;
            word_cnt <= '0;
            pkt_len  <= '0;
            pkt_sync <= 1'b0;
        end else begin
            pkt_sync <= seg_load;
            if (start_ok) begin
                remain <= i_frame_size;
            end else if (accept) begin
                remain <= remain - 16'd1;
            end
            if (seg_load) begin
                word_cnt <= seg_next;
                pkt_len  <= (seg_next + HDR_WORDS) << BYTE_SHIFT;
            end else if (accept) begin
                word_cnt <= word_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (i_frame_ready && (state != S_IDLE)
                     && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef FRAME_SEG_HDR_EN
    logic [SEG_WORDS_W-1:0] seg_words;
    logic [SEG_IDX_W-1:0]   seg_idx;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [31:0]            hdr_word;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_words <= '0;
            seg_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            if (seg_load) seg_words <= seg_next;
            if (start_ok) begin
                seg_idx <= '0;
            end else if (gap_end) begin
                seg_idx <= seg_idx + 1'b1;
            end
            if (gap_end && (remain == 16'd0)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign hdr_word = pack_hdr(frame_cnt, seg_idx, seg_words);
`endif

    always_comb begin
        o_out_vld  = 1'b0;
        o_in_rdy   = 1'b0;
        o_out_data = '0;
        case (state)
`ifdef FRAME_SEG_HDR_EN
            S_HDR: begin
                o_out_vld  = 1'b1;
                o_out_data = hdr_word;
            end
`endif
            S_DATA: begin
                o_out_data = i_in_data;
                o_out_vld  = i_in_vld;
                o_in_rdy   = i_out_rdy;
            end
            default: ;
        endcase
    end

    assign o_busy       = (state != S_IDLE);
    assign o_pkt_sync   = pkt_sync;
    assign o_pkt_len    = pkt_len;
    assign o_frame_drop = drop_cnt;

endmodule

// File: doc/frame_segmenter.md
# frame_segmenter

Sequences transmission of acquired scope frames over UDP on the `sys_clk` domain. It sits between the scope acquisition core's 32-bit frame stream and the UDP packet sender. On each frame-ready pulse it splits the frame into packets of at most `MAX_PKT_WORDS` words. For each packet it issues a start pulse and byte length to the sender, then gates exactly that many stream words through.

## Interface

Parameters:
- `MAX_PKT_WORDS`, default 360. Maximum payload words per packet (360 words = 1440 bytes). Legal range 1..4095.
- `GAP_CYCLES`, default 16. Idle cycles enforced after the last word of each packet. Legal range 1..255.

Ports:
- `sys_clk`, input, 1. The block's only clock.
- `rst_n`, input, 1. Asynchronous, active-low reset.
- `i_frame_ready`, input, 1. Single-cycle pulse meaning a frame is available.
- `i_frame_size`, input, 16. Frame length in 32-bit words. Valid in the `i_frame_ready` cycle.
- `i_in_data`, input, 32. Upstream frame stream data.
- `i_in_vld`, input, 1. Upstream valid.
- `o_in_rdy`, output, 1. Upstream ready.
- `o_out_data`, output, 32. Stream data to the packet sender.
- `o_out_vld`, output, 1. Valid to the packet sender.
- `i_out_rdy`, input, 1. Ready from the packet sender.
- `o_pkt_sync`, output, 1. One-cycle pulse marking the start of a packet.
- `o_pkt_len`, output, 16. Packet length in bytes, held from `o_pkt_sync` until the next packet.
- `o_busy`, output, 1. High whenever the FSM is not in IDLE.
- `o_frame_drop`, output, 16. Count of frame-ready pulses ignored; saturates at 0xFFFF.

## Operation

- FSM states: IDLE, START, HDR, DATA, GAP.
- **IDLE**
  - `i_frame_ready` with `i_frame_size` ≠ 0: latch `remain = i_frame_size`, clear `seg_idx`, go to START.
  - Size 0: ignored, no drop count.
- **START**
  - `seg_words = min(remain, MAX_PKT_WORDS)`.
  - `o_pkt_len = (seg_words + H) << 2`, where H = 1 with the header feature, 0 without.
  - Pulse `o_pkt_sync`.
  - Go to HDR if the header feature is enabled, else DATA.
- **HDR**
  - Drive the header word `{frame_cnt[7:0], seg_idx[7:0], seg_words[15:0]}` with `o_out_vld = 1` and `o_in_rdy = 0`.
  - On `i_out_rdy`, go to DATA.
- **DATA**
  - Pass-through: `o_out_data = i_in_data`, `o_out_vld = i_in_vld`, `o_in_rdy = i_out_rdy`.
  - Each accepted word (`i_in_vld & i_out_rdy`) decrements `word_cnt` (loaded with `seg_words`) and `remain`.
  - On the last word of the segment, go to GAP.
- **GAP**
  - Count `GAP_CYCLES` cycles, then `seg_idx++`.
  - If `remain ≠ 0`, go to START; else increment `frame_cnt` (wraps at 8 bits) and go to IDLE.
- Outside HDR and DATA: `o_out_vld = 0` and `o_in_rdy = 0`. No upstream word is ever consumed outside DATA.
- `i_frame_ready` in any state other than IDLE (including the IDLE→START transition cycle): ignored, `o_frame_drop` increments.
- Widths:
  - `remain` and `word_cnt` are 16 bits.
  - The length computation is 16-bit unsigned. Overflow is impossible within the legal parameter range.

## Timing

- Reset values:
  - All outputs 0, except `o_out_data`, which is 0 when not in DATA.
  - State IDLE; `frame_cnt`, `seg_idx` and the drop counter are 0.
- Latency: `i_frame_ready` at cycle N gives `o_pkt_sync` at N+2 (IDLE→START registered, pulse registered from START).
- First data/header `o_out_vld` can assert at N+3.
- `o_pkt_len` is stable from the `o_pkt_sync` cycle until the next START.
- DATA path is combinational pass-through, zero latency. Full throughput is one word per cycle.
- Packet-to-packet spacing is at least `GAP_CYCLES + 1` cycles from the last data word to the next `o_pkt_sync`.
- `i_out_rdy` low: stall with no loss; the header is held stable until accepted.
- `rst_n` asserted mid-packet: immediate return to IDLE with outputs deasserted. Partially sent frames are abandoned; upstream flushing is the source's responsibility.

## Configuration

- Macro: `FRAME_SEG_HDR_EN`.
- Defined:
  - HDR state and header word are compiled in.
  - `o_pkt_len` includes 4 header bytes.
  - The `frame_cnt` and `seg_idx` registers exist.
- Undefined:
  - START goes directly to DATA.
  - `o_pkt_len = seg_words << 2`.
  - Header logic and counters are removed.

## Structure

- Shared package `frame_seg_pkg` holds:
  - the FSM state enumeration;
  - header field widths and offsets (`FRAME_CNT_W = 8`, `SEG_IDX_W = 8`, `SEG_WORDS_W = 16`);
  - the bytes-per-word shift constant (2).
- One sub-module, `frame_seg_gap_timer`, implements the loadable down-counter for GAP with `load` and `done` signals.
- Everything else stays in `frame_segmenter`.

## Test plan

- Frame of 100 words, sender always ready:
  - one `o_pkt_sync` at N+2;
  - `o_pkt_len` = 400 (404 with the header);
  - 100 words out in order, then IDLE.
- Frame of 1000 words, `MAX_PKT_WORDS` = 360:
  - three packets, lengths 1440/1440/1120 bytes (+4 each with the header);
  - header `seg_idx` 0, 1, 2;
  - at least 16 idle cycles between packets.
- Random `i_out_rdy` and `i_in_vld` throttling on a 720-word frame: data matches the source exactly, no duplicated or lost words.
- Second `i_frame_ready` during DATA, and a pulse with size 0 in IDLE: `o_frame_drop` = 1 and the frame in progress is unaffected.
- `rst_n` asserted in the middle of DATA: all outputs are 0 within the same cycle; the next frame starts with `seg_idx` = 0 and `frame_cnt` = 0.
- 256 consecutive single-word frames with the header enabled: `frame_cnt` wraps from 255 back to 0.
